// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller and its forwarding units.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W = 4;
  localparam int unsigned FWD_W = 2;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [FWD_W-1:0] FWD_REGFILE = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB      = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM     = 2'b10;

  localparam logic [31:0]      NOP_INSTR   = 32'h0;
  localparam logic [REG_W-1:0] REG_PC      = 4'd15;

  // Pipeline sequencing controls decoded together each cycle
  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic if_id_flush;
    logic cu_mux_select;
    logic pipe_enable;
  } ctrl_t;

  localparam ctrl_t CTRL_HOLD   = '{pc_enable: 1'b0, if_id_enable: 1'b0, if_id_flush: 1'b0,
                                    cu_mux_select: 1'b1, pipe_enable: 1'b1};
  localparam ctrl_t CTRL_STALL  = CTRL_HOLD;
  localparam ctrl_t CTRL_FREEZE = '{pc_enable: 1'b0, if_id_enable: 1'b0, if_id_flush: 1'b0,
                                    cu_mux_select: 1'b0, pipe_enable: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_enable: 1'b1, if_id_enable: 1'b1, if_id_flush: 1'b1,
                                    cu_mux_select: 1'b0, pipe_enable: 1'b1};
  localparam ctrl_t CTRL_RUN    = '{pc_enable: 1'b1, if_id_enable: 1'b1, if_id_flush: 1'b0,
                                    cu_mux_select: 1'b0, pipe_enable: 1'b1};

  // True when a writing pipeline stage targets the given source register
  function automatic logic reg_match(input logic we, input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] src);
    return we && (rd == src);
  endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding select for a single source register.
module forwarding_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [FWD_W-1:0] fwd_sel_c
);

  // Youngest producer wins; the PC is never forwarded
  always_comb begin
    fwd_sel_c = FWD_REGFILE;
    if (src != REG_PC) begin
      if (reg_match(mem_reg_write, mem_rd, src)) begin
        fwd_sel_c = FWD_MEM;
      end else if (reg_match(wb_reg_write, wb_rd, src)) begin
        fwd_sel_c = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequences the 5-stage pipeline: post-reset hold, load-use stalls,
// taken-branch flushes, data-memory freezes and operand forwarding.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES = 2,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_rn_used,
  input  logic             id_rm_used,
  input  logic             br_taken,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic             dmem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             cu_mux_select,
  output logic             pipe_enable,
  output logic [FWD_W-1:0] fwd_a_sel,
  output logic [FWD_W-1:0] fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned HOLD_W  = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t               state, state_nxt;
  logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
  logic [FLUSH_W-1:0]   flush_cnt, flush_nxt;
  logic                 stall_inc;
  logic                 load_use;
  ctrl_t                ctrl;
  logic [FWD_W-1:0]     fwd_a_c, fwd_b_c;

  // Load in EX whose destination feeds an operand of the instruction in ID
  assign load_use = ex_mem_to_reg & ex_reg_write &
                    ((id_rn_used & (ex_rd == id_rn)) | (id_rm_used & (ex_rd == id_rm)));

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      flush_cnt <= flush_nxt;
    end
  end

  // Next-state and control decode; priority freeze > load-use > branch
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    flush_nxt = flush_cnt;
    stall_inc = 1'b0;
    ctrl      = CTRL_RUN;
    case (state)
      ST_HOLD: begin
        ctrl = CTRL_HOLD;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (dmem_busy) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else if (load_use) begin
          ctrl      = CTRL_STALL;
          stall_inc = 1'b1;
        end else if (br_taken) begin
          ctrl = CTRL_FLUSH;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = ST_FLUSH;
            flush_nxt = FLUSH_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (dmem_busy) begin
          ctrl      = CTRL_FREEZE;
          stall_inc = 1'b1;
        end else begin
          ctrl = CTRL_FLUSH;
          if (flush_cnt == FLUSH_LAST) begin
            state_nxt = ST_RUN;
            flush_nxt = '0;
          end else begin
            flush_nxt = flush_cnt + FLUSH_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_HOLD;
        hold_nxt  = '0;
        flush_nxt = '0;
        ctrl      = CTRL_HOLD;
      end
    endcase
  end

  // Saturating count of stall and freeze cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall_inc && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign pc_enable     = ctrl.pc_enable;
  assign if_id_enable  = ctrl.if_id_enable;
  assign if_id_flush   = ctrl.if_id_flush;
  assign cu_mux_select = ctrl.cu_mux_select;
  assign pipe_enable   = ctrl.pipe_enable;

  forwarding_unit u_fwd_a (
    .src           (id_rn),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel_c     (fwd_a_c)
  );

  forwarding_unit u_fwd_b (
    .src           (id_rm),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel_c     (fwd_b_c)
  );

  // Forwarding is suppressed while reset is asserted
  assign fwd_a_sel = reset ? FWD_REGFILE : fwd_a_c;
  assign fwd_b_sel = reset ? FWD_REGFILE : fwd_b_c;

endmodule
